// File: rtl/mem_pkg.sv
// Shared load/store encodings and helpers for the byte-serial memory access unit.
// Width codes follow the RISC-V funct3 field; LB/SB, LH/SH and LW/SW share values.
package mem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } MemFunct3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } MauState;

  function automatic logic [2:0] byteCount(MemFunct3 f);
    case (f)
      F3_B, F3_BU: byteCount = 3'd1;
      F3_H, F3_HU: byteCount = 3'd2;
      default:     byteCount = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extendLoad(logic [31:0] raw, MemFunct3 f);
    case (f)
      F3_B:    extendLoad = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   extendLoad = {24'h000000, raw[7:0]};
      F3_H:    extendLoad = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   extendLoad = {16'h0000, raw[15:0]};
      default: extendLoad = raw;
    endcase
  endfunction

  // Stores only have byte/half/word; loads add the two unsigned variants.
  function automatic logic isLegal(logic we, logic [2:0] f3);
    if (we) isLegal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    isLegal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Byte-serial RISC-V load/store unit driving an 8-bit RAM port, one byte per cycle.
// Loads assemble little-endian lanes and extend on the edge that enters DONE.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  MauState           r_state;
  MemFunct3          r_f3;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_lanes;
  logic [31:0]       r_rdata;
  logic [1:0]        r_idx;

  logic              w_access;
  logic              w_last;
  logic [31:0]       w_lanes;

  assign w_access = (r_state == ACCESS);
  assign w_last   = (r_idx == 2'(byteCount(r_f3) - 3'd1));

  // Current byte merged into its lane so the final edge can extend without an extra cycle.
  always_comb begin
    w_lanes = r_lanes;
    w_lanes[{r_idx, 3'b000} +: 8] = mem_rdata;
  end

  assign mem_addr  = w_access ? (r_addr + ADDR_W'(r_idx)) : '0;
  assign mem_we    = w_access & r_we;
  assign mem_wdata = w_access ? r_wdata[{r_idx, 3'b000} +: 8] : 8'h00;

  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_f3    <= F3_B;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_lanes <= 32'h0;
      r_rdata <= 32'h0;
      r_idx   <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (req) begin
            r_busy <= 1'b1;
            if (isLegal(we, funct3)) begin
              r_state <= ACCESS;
              r_f3    <= MemFunct3'(funct3);
              r_we    <= we;
              r_addr  <= addr;
              r_wdata <= wdata;
              r_lanes <= 32'h0;
              r_idx   <= 2'd0;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          r_lanes <= w_lanes;
          r_idx   <= r_idx + 2'd1;
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            if (!r_we) r_rdata <= extendLoad(w_lanes, r_f3);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts every
// output cycle by cycle, and literal expectations pin the model's results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Bench RAM (written by DUT or preload port) and the model's shadow copy.
  logic [7:0]  mem  [0:4095] = '{default: 8'h00};
  logic [7:0]  smem [0:4095] = '{default: 8'h00};
  logic        pl_we = 1'b0;
  logic [11:0] pl_a = 12'h0;
  logic [7:0]  pl_d = 8'h00;

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[11:0]] <= mem_wdata;
    else if (pl_we) mem[pl_a] <= pl_d;
  end
  assign mem_rdata = mem[mem_addr[11:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model of the transaction in flight
  bit          active = 1'b0;
  bit          susp = 1'b1;
  int          base = 0;
  int          mN = 0;
  bit          mwe = 1'b0;
  bit          merr = 1'b0;
  logic [31:0] ma = 32'h0;
  logic [31:0] mwd = 32'h0;
  logic [31:0] old_rd = 32'h0;
  logic [31:0] new_rd = 32'h0;

  int          k;
  bit          win, acc;
  logic [31:0] e_addr;
  always @(negedge clk) begin
    if (!susp) begin
      k      = active ? (cyc - base + 1) : 0;
      win    = active && (k >= 1) && (k <= mN + 1);
      acc    = win && (k <= mN);
      e_addr = acc ? (ma + 32'(k - 1)) : 32'h0;
      chk("busy", {31'h0, busy}, {31'h0, win});
      chk("done", {31'h0, done}, {31'h0, win && (k == mN + 1)});
      chk("err", {31'h0, err}, {31'h0, win && (k == mN + 1) && merr});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", {31'h0, mem_we}, {31'h0, acc && mwe});
      if (acc && mwe) chk("mem_wdata", {24'h0, mem_wdata}, {24'h0, mwd[8*(k-1) +: 8]});
      else if (!acc)  chk("mem_wdata_idle", {24'h0, mem_wdata}, 32'h0);
      chk("rdata", rdata, (active && k >= mN + 1) ? new_rd : old_rd);
    end
  end

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d; smem[a] = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic access(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit use_lit,
                        input logic [31:0] lit, input string nm, output int we_cnt);
    bit          legal;
    int          n;
    logic [31:0] raw, ext, s;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    n = !legal ? 0 : (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    raw = 32'h0;
    for (int j = 0; j < n; j++) begin
      s = a + 32'(j);
      raw[8*j +: 8] = smem[s[11:0]];
    end
    ext = raw;
    if (f3[2] == 1'b0 && n < 4 && raw[8*n-1]) ext = raw | (32'hFFFF_FFFF << (8*n));
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    base = cyc; mN = n; mwe = w; merr = !legal; ma = a; mwd = wd;
    new_rd = (legal && !w) ? ext : old_rd;
    active = 1'b1;
    // Keep req asserted with junk inputs: a busy unit must ignore it.
    addr = ~a; wdata = ~wd; funct3 = 3'b010; we = ~w;
    we_cnt = int'(mem_we);
    for (int j = 1; j <= n + 1; j++) begin
      @(posedge clk); #1;
      we_cnt += int'(mem_we);
      if (j == n) chk({nm, "_done_latency"}, {31'h0, done}, 32'h1);
    end
    req = 1'b0;
    active = 1'b0;
    old_rd = new_rd;
    if (legal && w)
      for (int j = 0; j < n; j++) begin
        s = a + 32'(j);
        smem[s[11:0]] = wd[8*j +: 8];
      end
    if (use_lit) chk(nm, rdata, lit);
  endtask

  int wc;
  int bad_mem;
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; susp = 1'b0;
    @(posedge clk); #1;

    preload(12'h080, 8'h58); preload(12'h081, 8'h00);
    preload(12'h082, 8'h00); preload(12'h083, 8'h00);
    access(1'b0, 3'b010, 32'h80, 32'h0, 1'b1, 32'h0000_0058, "lw_0x80", wc);

    preload(12'h081, 8'h80); preload(12'h082, 8'hFF);
    access(1'b0, 3'b000, 32'h81, 32'h0, 1'b1, 32'hFFFF_FF80, "lb_0x81", wc);
    access(1'b0, 3'b100, 32'h81, 32'h0, 1'b1, 32'h0000_0080, "lbu_0x81", wc);
    access(1'b0, 3'b101, 32'h81, 32'h0, 1'b1, 32'h0000_FF80, "lhu_0x81", wc);
    access(1'b0, 3'b001, 32'h81, 32'h0, 1'b1, 32'hFFFF_FF80, "lh_0x81", wc);

    preload(12'h100, 8'h11); preload(12'h103, 8'h33);
    access(1'b1, 3'b001, 32'h101, 32'h1234_BEEF, 1'b0, 32'h0, "sh_0x101", wc);
    chk("sh_we_cycles", 32'(wc), 32'd2);
    chk("sh_mem_101", {24'h0, mem[12'h101]}, 32'hEF);
    chk("sh_mem_102", {24'h0, mem[12'h102]}, 32'hBE);
    chk("sh_mem_100", {24'h0, mem[12'h100]}, 32'h11);
    chk("sh_mem_103", {24'h0, mem[12'h103]}, 32'h33);

    preload(12'hFFE, 8'h01); preload(12'hFFF, 8'h02);
    preload(12'h000, 8'h03); preload(12'h001, 8'h04);
    access(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1'b1, 32'h0403_0201, "lw_wrap", wc);

    access(1'b0, 3'b011, 32'h80, 32'h0, 1'b1, 32'h0403_0201, "bad_load_holds", wc);
    chk("bad_load_we", 32'(wc), 32'd0);
    access(1'b1, 3'b100, 32'h80, 32'hDEAD_BEEF, 1'b1, 32'h0403_0201, "bad_store_holds", wc);
    chk("bad_store_we", 32'(wc), 32'd0);

    access(1'b1, 3'b000, 32'h300, 32'hFFFF_FF5A, 1'b0, 32'h0, "sb_0x300", wc);
    chk("sb_we_cycles", 32'(wc), 32'd1);
    access(1'b0, 3'b100, 32'h300, 32'h0, 1'b1, 32'h0000_005A, "lbu_0x300", wc);
    access(1'b1, 3'b010, 32'h304, 32'h8765_4321, 1'b0, 32'h0, "sw_0x304", wc);
    chk("sw_we_cycles", 32'(wc), 32'd4);
    access(1'b0, 3'b001, 32'h306, 32'h0, 1'b1, 32'hFFFF_8765, "lh_0x306", wc);

    // Reset in the middle of a word store, after two bytes have been written.
    preload(12'h202, 8'h77); preload(12'h203, 8'h66);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h200; wdata = 32'hAABB_CCDD;
    @(posedge clk); #1;
    base = cyc; mN = 4; mwe = 1'b1; merr = 1'b0; ma = 32'h200; mwd = 32'hAABB_CCDD;
    new_rd = old_rd; active = 1'b1; req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0; susp = 1'b1; active = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    old_rd = 32'h0; new_rd = 32'h0;
    smem[12'h200] = 8'hDD; smem[12'h201] = 8'hCC;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; susp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_mem_200", {24'h0, mem[12'h200]}, 32'hDD);
    chk("abort_mem_201", {24'h0, mem[12'h201]}, 32'hCC);
    chk("abort_mem_202", {24'h0, mem[12'h202]}, 32'h77);
    chk("abort_mem_203", {24'h0, mem[12'h203]}, 32'h66);
    access(1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 32'h6677_CCDD, "lw_after_abort", wc);

    bad_mem = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== smem[i]) bad_mem++;
    chk("ram_image", 32'(bad_mem), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
